alu_3bit: RTL and testbench
===========================

Name: alu_3bit

Overview:
- Registered 3-bit arithmetic/logic unit with carry, sign and zero flags.
- Inputs A, B and a 2-bit opcode are sampled on a clock edge when in_valid is high.
- Result and flags are presented on registered outputs one cycle later.
- Used as a small datapath execution element; all outputs come straight from flops.

Parameters:
- W, 3, operand/result width in bits (spec values below assume W=3).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample A/B/OP this cycle.
- A  input  W  operand A, unsigned.
- B  input  W  operand B, unsigned.
- OP  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
- R  output  W  registered result.
- CF  output  1  registered carry/borrow flag.
- SF  output  1  registered sign flag.
- ZF  output  1  registered zero flag.
- out_valid  output  1  high for the one cycle after an accepted input.

Behaviour:
- Reset (async assert, sync release): R=0, CF=0, SF=0, ZF=1, out_valid=0. Reset mid-operation discards the pending result.
- Latency is 1 cycle. On the rising edge with in_valid=1, R and the flags load from the combinational result of A, B and OP, and out_valid=1.
- On an edge with in_valid=0, R and the flags hold their previous values and out_valid=0.
- Back-to-back accepts are allowed (one result per cycle) with no stall or backpressure.
- ADD: {CF,R} = A + B, full W+1-bit sum. CF is the carry out of the MSB.
- SUB: R = (A - B) mod 2^W. CF = 1 exactly when A < B unsigned (borrow).
- AND: R = A & B; CF=0.
- OR: R = A | B; CF=0.
- SF = R[W-1] for all ops.
- ZF = 1 when R == 0, for all ops.
- No overflow flag; signed overflow is not reported.
- X/Z on inputs is not required to be handled when in_valid=0.

Decomposition:
- Shared package alu_pkg:
  - opcode enum alu_op_e (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11);
  - flag struct alu_flags_t {cf, sf, zf};
  - localparam default width 3.
- One combinational sub-module, alu_core. It takes A, B and OP and produces the next R and flags.
- The top level holds the flops, out_valid and reset.

Test Plan:
- Reset asserted asynchronously mid-cycle -> R=000, CF=0, SF=0, ZF=1, out_valid=0 immediately. Release, then idle cycles -> outputs unchanged.
- ADD A=100, B=011 -> next cycle R=111, CF=0, SF=1, ZF=0. ADD A=111, B=111 -> R=110, CF=1, SF=1, ZF=0.
- SUB A=100, B=010 -> R=010, CF=0, SF=0, ZF=0. SUB A=001, B=111 -> R=010, CF=1, SF=0, ZF=0. SUB A=011, B=011 -> R=000, CF=0, ZF=1.
- AND A=111, B=010 -> R=010, CF=0, SF=0, ZF=0. OR A=110, B=001 -> R=111, CF=0, SF=1, ZF=0.
- Hold/throughput: accept four ops back-to-back -> one result per cycle, in order, out_valid high four cycles. Drop in_valid with changing A/B -> R and flags hold, out_valid=0.
- Randomized sweep of all 2^(2W+2) A/B/OP combos against a reference model -> R, CF, SF, ZF match with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the registered 3-bit ALU.
//   alu_op_e    : 2-bit opcode (ADD, SUB, AND, OR)
//   alu_flags_t : carry/borrow, sign and zero flags
//   ALU_W       : default operand/result width
package alu_pkg;

  localparam int ALU_W = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic cf;
    logic sf;
    logic zf;
  } alu_flags_t;

  // Flag value that goes with a zero result and no carry.
  localparam alu_flags_t FLAGS_RESET = '{cf: 1'b0, sf: 1'b0, zf: 1'b1};

endpackage : alu_pkg

// File: rtl/alu_3bit_if.sv
// Bus between the ALU and its producer/consumer.
//   in_valid, A, B, OP : request side, sampled on the clock edge when in_valid=1
//   R, CF, SF, ZF      : registered result and flags
//   out_valid          : high for the one cycle after an accepted request
// master : drives the request and observes the result (testbench / upstream)
// slave  : the ALU itself
interface alu_3bit_if
  import alu_pkg::*;
#(
  parameter int W = ALU_W
);

  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   OP;
  logic [W-1:0] R;
  logic         CF;
  logic         SF;
  logic         ZF;
  logic         out_valid;

  modport master (
    output in_valid, A, B, OP,
    input  R, CF, SF, ZF, out_valid
  );

  modport slave (
    input  in_valid, A, B, OP,
    output R, CF, SF, ZF, out_valid
  );

endinterface : alu_3bit_if

// File: rtl/alu_3bit_core.sv
// Combinational ALU datapath: computes the next result and flags from A, B, OP.
//   a_i, b_i : unsigned operands
//   op_i     : opcode
//   r_o      : result, modulo 2^W
//   flags_o  : carry/borrow, sign (MSB of result), zero
module alu_core
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [W-1:0] r_o,
  output alu_flags_t   flags_o
);

  logic [W:0] sum;
  logic [W:0] diff;

  // Both operands are zero-extended by one bit, so sum[W] is the carry out
  // and diff[W] is set exactly when the subtraction wraps, i.e. A < B.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    r_o        = '0;
    flags_o.cf = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        r_o        = sum[W-1:0];
        flags_o.cf = sum[W];
      end
      OP_SUB: begin
        r_o        = diff[W-1:0];
        flags_o.cf = diff[W];
      end
      OP_AND: r_o = a_i & b_i;
      OP_OR:  r_o = a_i | b_i;
      default: ;
    endcase
    flags_o.sf = r_o[W-1];
    flags_o.zf = (r_o == '0);
  end

endmodule : alu_core

// File: rtl/alu_3bit.sv
// Registered 3-bit ALU with carry, sign and zero flags, one-cycle latency.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (release is expected to be synchronous)
//   bus : alu_3bit_if slave modport (in_valid/A/B/OP in, R/CF/SF/ZF/out_valid out)
// Every output comes straight from a flop. Results and flags hold while
// in_valid is low; out_valid pulses for one cycle per accepted request.
module alu_3bit
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic        clk,
  input  logic        rst,
  alu_3bit_if.slave   bus
);

  logic [W-1:0] r_d;
  logic [W-1:0] r_q;
  alu_flags_t   flags_d;
  alu_flags_t   flags_q;
  logic         valid_q;

  alu_core #(.W(W)) u_core (
    .a_i     (bus.A),
    .b_i     (bus.B),
    .op_i    (alu_op_e'(bus.OP)),
    .r_o     (r_d),
    .flags_o (flags_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      flags_q <= FLAGS_RESET;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        r_q     <= r_d;
        flags_q <= flags_d;
      end
    end
  end

  assign bus.R         = r_q;
  assign bus.CF        = flags_q.cf;
  assign bus.SF        = flags_q.sf;
  assign bus.ZF        = flags_q.zf;
  assign bus.out_valid = valid_q;

endmodule : alu_3bit

// File: tb/tb_alu_3bit.sv
// Self-checking bench for alu_3bit: directed table, back-to-back / hold /
// reset sequences, then a randomized-order sweep of every A/B/OP combination
// checked against an arithmetic reference model.
module tb_alu_3bit;
  import alu_pkg::*;

  localparam int W   = 3;
  localparam int MOD = 1 << W;

  logic clk;
  logic rst;

  alu_3bit_if #(.W(W)) bus ();

  alu_3bit #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected registered outputs, maintained by the bench.
  logic [W-1:0] exp_r;
  logic         exp_cf, exp_sf, exp_zf, exp_v;

  typedef struct {
    logic [W-1:0] r;
    logic         cf;
    logic         sf;
    logic         zf;
  } res_t;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         cf;
    logic         sf;
    logic         zf;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Reference model from the arithmetic definition of each opcode.
  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t res;
    int   ia, ib, s;
    ia     = int'(a);
    ib     = int'(b);
    res.cf = 1'b0;
    case (op)
      2'b00: begin
        s      = ia + ib;
        res.r  = W'(s % MOD);
        res.cf = (s >= MOD);
      end
      2'b01: begin
        s      = (ia - ib + MOD) % MOD;
        res.r  = W'(s);
        res.cf = (ia < ib);
      end
      2'b10:   res.r = a & b;
      default: res.r = a | b;
    endcase
    res.sf = (int'(res.r) >= MOD / 2);
    res.zf = (int'(res.r) == 0);
    return res;
  endfunction

  function automatic logic [15:0] pack_dut();
    return {9'd0, bus.R, bus.CF, bus.SF, bus.ZF, bus.out_valid};
  endfunction

  function automatic logic [15:0] pack_exp();
    return {9'd0, exp_r, exp_cf, exp_sf, exp_zf, exp_v};
  endfunction

  task automatic set_exp_reset();
    exp_r  = '0;
    exp_cf = 1'b0;
    exp_sf = 1'b0;
    exp_zf = 1'b1;
    exp_v  = 1'b0;
  endtask

  // Drive at the falling edge, let the rising edge sample, check at the next
  // falling edge. Consecutive calls give one request per cycle.
  task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input string name);
    res_t m;
    bus.in_valid = v;
    bus.OP       = op;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    exp_v = v;
    if (v) begin
      m      = model(op, a, b);
      exp_r  = m.r;
      exp_cf = m.cf;
      exp_sf = m.sf;
      exp_zf = m.zf;
    end
    @(negedge clk);
    check(name, pack_dut(), pack_exp());
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"add_100_011", 2'b00, 3'b100, 3'b011, 3'b111, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"add_111_111", 2'b00, 3'b111, 3'b111, 3'b110, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"sub_100_010", 2'b01, 3'b100, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"sub_001_111", 2'b01, 3'b001, 3'b111, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"sub_011_011", 2'b01, 3'b011, 3'b011, 3'b000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{"and_111_010", 2'b10, 3'b111, 3'b010, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"or_110_001",  2'b11, 3'b110, 3'b001, 3'b111, 1'b0, 1'b1, 1'b0};

    bus.in_valid = 1'b0;
    bus.OP       = 2'b00;
    bus.A        = '0;
    bus.B        = '0;
    rst          = 1'b1;
    set_exp_reset();
    #1;
    check("reset_state", pack_dut(), pack_exp());

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 2'b01, 3'(i + 2), 3'(i), "idle_after_reset");

    // Directed vectors: model check inside step, plus the hand-computed table.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].name, "_model"});
      check({vecs[i].name, "_table"}, pack_dut(),
            {9'd0, vecs[i].r, vecs[i].cf, vecs[i].sf, vecs[i].zf, 1'b1});
    end

    // Four back-to-back accepts, then idle cycles with moving operands.
    step(1'b1, 2'b00, 3'd3, 3'd4, "b2b_0");
    step(1'b1, 2'b01, 3'd2, 3'd5, "b2b_1");
    step(1'b1, 2'b10, 3'd6, 3'd3, "b2b_2");
    step(1'b1, 2'b11, 3'd1, 3'd4, "b2b_3");
    for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 3'(7 - i), 3'(i * 3), "hold");

    // Asynchronous reset mid-cycle with a request pending.
    step(1'b1, 2'b00, 3'd7, 3'd7, "pre_reset_add");
    bus.in_valid = 1'b1;
    bus.OP       = 2'b11;
    bus.A        = 3'b110;
    bus.B        = 3'b001;
    #2 rst = 1'b1;
    set_exp_reset();
    #1;
    check("async_reset_immediate", pack_dut(), pack_exp());
    @(negedge clk);
    check("reset_discards_pending", pack_dut(), pack_exp());
    rst = 1'b0;
    step(1'b0, 2'b00, 3'd5, 3'd5, "idle_after_reset2");

    // Every opcode/operand combination once, in a random order, with random gaps.
    begin
      int mul, off, idx;
      mul = int'($urandom_range(0, 127)) * 2 + 1;
      off = int'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) begin
        idx = (i * mul + off) % 256;
        if ($urandom_range(0, 3) == 0)
          step(1'b0, 2'($urandom), 3'($urandom), 3'($urandom), "sweep_gap");
        step(1'b1, idx[7:6], idx[5:3], idx[2:0], "sweep");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu_3bit
